// File: rtl/mul_multicycle_ext.sv
// rtl/mul_multicycle_ext.sv - iterative M-extension multiplier (MUL/MULH/MULHSU/MULHU), req/ack handshake
// Retires BITS_PER_CYCLE multiplier bits per step on operand magnitudes, then applies the result sign.
module mul_multicycle_ext #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             ack,
   output logic             busy
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             sign_q, sign_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]    partial, res;

   assign a_neg   = (op == 2'b01 || op == 2'b10) && a[WIDTH-1];
   assign b_neg   = (op == 2'b01) && b[WIDTH-1];
   assign a_mag   = a_neg ? -a : a;
   assign b_mag   = b_neg ? -b : b;
   // a_sh_q is already aligned to the current digit position, so no variable shift is needed
   assign partial = a_sh_q * PW'(b_sh_q[BITS_PER_CYCLE-1:0]);
   assign res     = sign_q ? -acc_q : acc_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sign_d  = sign_q;
      acc_d   = acc_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            // also accepts during the ack cycle, giving one op per N+2 cycles
            busy_d = req;
            if (req) begin
               op_d    = op;
               sign_d  = a_neg ^ b_neg;
               acc_d   = '0;
               a_sh_d  = PW'(a_mag);
               b_sh_d  = b_mag;
               cnt_d   = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d  = acc_q + partial;
            a_sh_d = a_sh_q << BITS_PER_CYCLE;
            b_sh_d = b_sh_q >> BITS_PER_CYCLE;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            out_d   = (op_q == 2'b00) ? res[WIDTH-1:0] : res[PW-1:WIDTH];
            ack_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         sign_q  <= 1'b0;
         acc_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sign_q  <= sign_d;
         acc_q   <= acc_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   assign out  = out_q;
   assign ack  = ack_q;
   assign busy = busy_q;

   a_operands_known: assert property (@(posedge clk) disable iff (!rst)
      (state_q == S_IDLE && req) |-> !$isunknown({op, a, b}));

endmodule

// File: tb/tb_mul_multicycle_ext.sv
// tb/tb_mul_multicycle_ext.sv - scoreboard bench for mul_multicycle_ext (32/2 directed, 16/4 random)
module tb_mul_multicycle_ext;

   localparam int N_W = 16;
   localparam int N_N = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_w = 1'b0, ack_w, busy_w;
   logic [1:0]  op_w = '0;
   logic [31:0] a_w = '0, b_w = '0, out_w;
   logic        req_n = 1'b0, ack_n, busy_n;
   logic [1:0]  op_n = '0;
   logic [15:0] a_n = '0, b_n = '0, out_n;

   mul_multicycle_ext #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut_w (
      .clk(clk), .rst(rst), .req(req_w), .op(op_w), .a(a_w), .b(b_w),
      .out(out_w), .ack(ack_w), .busy(busy_w));

   mul_multicycle_ext #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut_n (
      .clk(clk), .rst(rst), .req(req_n), .op(op_n), .a(a_n), .b(b_n),
      .out(out_n), .ack(ack_n), .busy(busy_n));

   typedef struct {
      logic [31:0] val;
      int          at;
   } exp_t;

   exp_t q_w[$];
   exp_t q_n[$];
   exp_t e_w, e_n;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] sa, sb, p;
      sa = (op == 2'b01 || op == 2'b10) ? {{16{a[15]}}, a} : {16'h0, a};
      sb = (op == 2'b01) ? {{16{b[15]}}, b} : {16'h0, b};
      p  = sa * sb;
      return (op == 2'b00) ? p[15:0] : p[31:16];
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (ack_w) begin
            if (q_w.size() == 0) begin
               check_eq("w_unexpected_ack", ack_w, 0);
            end else begin
               e_w = q_w.pop_front();
               check_eq("w_out", out_w, e_w.val);
               check_eq("w_ack_cycle", cyc, e_w.at);
            end
         end
         if (ack_n) begin
            if (q_n.size() == 0) begin
               check_eq("n_unexpected_ack", ack_n, 0);
            end else begin
               e_n = q_n.pop_front();
               check_eq("n_out", out_n, e_n.val);
               check_eq("n_ack_cycle", cyc, e_n.at);
            end
         end
      end
   end

   task automatic start_w(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      req_w = 1'b1;
      op_w  = op;
      a_w   = a;
      b_w   = b;
      q_w.push_back(exp_t'{exp, cyc + N_W + 2});
      @(negedge clk);
      req_w = 1'b0;
   endtask

   task automatic start_n(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      req_n = 1'b1;
      op_n  = op;
      a_n   = a;
      b_n   = b;
      q_n.push_back(exp_t'{{16'h0, ref16(op, a, b)}, cyc + N_N + 2});
      @(negedge clk);
      req_n = 1'b0;
   endtask

   task automatic wait_w();
      int t = 0;
      while (q_w.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (q_w.size() != 0) begin
         check_eq("w_timeout", q_w.size(), 0);
         q_w.delete();
      end
   endtask

   task automatic wait_n();
      int t = 0;
      while (q_n.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (q_n.size() != 0) begin
         check_eq("n_timeout", q_n.size(), 0);
         q_n.delete();
      end
   endtask

   logic [1:0]  c_op [6] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01};
   logic [31:0] c_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
   logic [31:0] c_b  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
   logic [31:0] c_r  [6] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [15:0] n_a  [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
   logic [15:0] n_b  [4] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h1234};

   initial begin
      int k;
      repeat (3) @(negedge clk);
      check_eq("rst_out_w", out_w, 0);
      check_eq("rst_ack_w", ack_w, 0);
      check_eq("rst_busy_w", busy_w, 0);
      check_eq("rst_out_n", out_n, 0);
      check_eq("rst_busy_n", busy_n, 0);
      rst = 1'b1;
      @(negedge clk);

      start_w(2'b00, 32'd7, 32'd6, 32'd42);
      wait_w();
      for (int i = 0; i < 6; i++) begin
         start_w(c_op[i], c_a[i], c_b[i], c_r[i]);
         wait_w();
      end

      // req held high while operands churn; back-to-back op at the earliest edge
      k = cyc + 1;
      req_w = 1'b1;
      op_w  = 2'b00;
      a_w   = 32'd5;
      b_w   = 32'd9;
      q_w.push_back(exp_t'{32'd45, k + N_W + 1});
      @(negedge clk);
      check_eq("hold_busy_start", busy_w, 1);
      while (cyc < k + N_W + 1) begin
         a_w = $urandom;
         b_w = $urandom;
         @(negedge clk);
      end
      check_eq("hold_busy_ack_cycle", busy_w, 1);
      a_w = 32'd10;
      b_w = 32'd11;
      q_w.push_back(exp_t'{32'd110, k + N_W + 2 + N_W + 1});
      @(negedge clk);
      req_w = 1'b0;
      a_w   = $urandom;
      check_eq("hold_busy_b2b", busy_w, 1);
      wait_w();
      @(negedge clk);
      check_eq("busy_drop", busy_w, 0);

      // abort mid-operation
      start_w(2'b00, 32'd123, 32'd456, 32'd56088);
      repeat (7) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("abort_out", out_w, 0);
      check_eq("abort_ack", ack_w, 0);
      check_eq("abort_busy", busy_w, 0);
      q_w.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (25) @(negedge clk);
      check_eq("abort_idle_busy", busy_w, 0);
      start_w(2'b00, 32'd3, 32'd4, 32'd12);
      wait_w();

      for (int i = 0; i < 4; i++) begin
         for (int o = 0; o < 4; o++) begin
            start_n(o[1:0], n_a[i], n_b[i]);
            wait_n();
         end
      end
      repeat (40) begin
         start_n(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
         wait_n();
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
